seq_101_frame_tx: RTL and testbench
===================================

SEQ_101_FRAME_TX -- requirements
Module: seq_101_frame_tx

Interface
REQ-001 Parameter PAYLOAD_W, default 8, payload bits per frame; legal range 2..16.
REQ-002 Parameter IDLE_LEVEL, default 1'b0, value driven on tx when no frame bit is being sent.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 start  input  1  frame request, sampled on every rising clk edge.
REQ-006 data_in  input  PAYLOAD_W  payload word, captured on the accepting edge.
REQ-007 busy  output  1  high while a frame is in progress.
REQ-008 tx  output  1  serial bit stream, registered.
REQ-009 tx_valid  output  1  high in every cycle where tx carries a frame bit (preamble, payload or stuffed).
REQ-010 done  output  1  one-cycle pulse marking end of frame.

Function
REQ-011 All outputs SHALL be registered; no combinational path from an input to any output.
REQ-012 States SHALL be IDLE, PRE, DATA, STUFF.
REQ-013 Acceptance: start=1 on an edge with busy=0 SHALL latch data_in and enter PRE. start while busy=1 SHALL be ignored, with no effect on the current frame.
REQ-014 The first frame bit SHALL appear on tx, with tx_valid=1 and busy=1, in the cycle after the accepting edge.
REQ-015 PRE SHALL emit preamble 1,0,1 on three consecutive cycles, then move to DATA.
REQ-016 DATA SHALL emit the payload MSB first, one bit per cycle.
REQ-017 Stuffing history SHALL be the last two transmitted bits, seeded with the final two preamble bits (0,1). Stuffed bits count as transmitted bits.
REQ-018 After any non-final payload bit, if the history is 1 then 0 (older, newer), the next cycle SHALL be STUFF and emit one 0. That 0 consumes no payload bit. The FSM then returns to DATA.
REQ-019 No stuffed bit SHALL follow the final payload bit.
REQ-020 Frame length SHALL be 3 + PAYLOAD_W + number of stuffed bits. The maximum is 15 cycles for PAYLOAD_W=8.
REQ-021 Resulting property: the pattern 1,0,1 SHALL NOT occur in the stream after the preamble's first bit, within one frame.
REQ-022 In the cycle after the last frame bit: busy=0, tx_valid=0, tx=IDLE_LEVEL, done=1 for exactly that one cycle.
REQ-023 start=1 during the done cycle SHALL be accepted, giving back-to-back frames separated by exactly one idle cycle.
REQ-024 In IDLE: tx=IDLE_LEVEL, tx_valid=0, busy=0, done=0 except for the pulse in REQ-022.
REQ-025 The payload bit index counter SHALL be wide enough for PAYLOAD_W and SHALL NOT wrap within a frame.

Reset
REQ-026 When reset=1 on an edge, the block SHALL enter IDLE with busy=0, tx=IDLE_LEVEL, tx_valid=0, done=0, stuffing history cleared, and latched payload discarded.
REQ-027 Reset SHALL take priority over start on the same edge.
REQ-028 Reset mid-frame SHALL abort the frame, with no done pulse. A start on the first edge after reset deasserts SHALL be accepted normally.

Verification
REQ-029 data_in=8'hFF, start pulse -> tx 1,0,1,1,1,1,1,1,1,1,1 (11 valid cycles, no stuffing); done in cycle 12 after acceptance.
REQ-030 data_in=8'h55 -> tx 1,0,1,0,0,1,0,0,1,0,0,1,0,0,1 (15 cycles, 4 stuffed zeros); done in cycle 16.
REQ-031 data_in=8'hA0 -> tx 1,0,1,1,0,0,1,0,0,0,0,0,0 (13 cycles, stuffed zeros after payload bits 1 and 3).
REQ-032 Start pulses while busy (data_in changed to 8'h00) during an 8'hFF frame -> frame output identical to REQ-029, no second frame.
REQ-033 Reset asserted in the 5th valid cycle of an 8'h55 frame -> next cycle busy=0, tx_valid=0, tx=IDLE_LEVEL, no done. A fresh 8'hFF start then gives the REQ-029 stream.
REQ-034 start held during the done cycle of frame 1 (8'hA0), with frame 2 data 8'h55 -> frame 2 begins exactly one cycle after done. Every frame 2 bit is decoded by a 1,0,1 non-overlapping detector reference model as a single preamble hit only.

Source files
------------

// File: rtl/seq_101_frame_tx.sv
// Serial frame transmitter: sends the preamble 1,0,1 and then the payload MSB first.
// A 0 is stuffed after any non-final payload bit that ends in 1,0, so 1,0,1 never recurs within a frame.
module seq_101_frame_tx #(
   parameter int   PAYLOAD_W  = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PAYLOAD_W-1:0] data_in,
   output logic                 busy,
   output logic                 tx,
   output logic                 tx_valid,
   output logic                 done
);

   localparam int CNT_W = $clog2(PAYLOAD_W + 1);

   typedef enum logic [1:0] {IDLE, PRE, DATA, STUFF} state_t;

   // The state names the bit currently on tx.
   // hist holds the last two bits sent, including the current one.
   state_t               state, state_nxt;
   logic [1:0]           pre_cnt, pre_cnt_nxt;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic [PAYLOAD_W-1:0] shreg, shreg_nxt;
   logic [1:0]           hist, hist_nxt;
   logic                 bit_nxt;
   logic                 last_bit;
   logic                 busy_nxt, tx_nxt, tx_valid_nxt, done_nxt;

   assign last_bit = (bit_cnt == CNT_W'(PAYLOAD_W));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pre_cnt  <= 2'd0;
         bit_cnt  <= '0;
         shreg    <= '0;
         hist     <= 2'b00;
         busy     <= 1'b0;
         tx       <= IDLE_LEVEL;
         tx_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pre_cnt  <= pre_cnt_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shreg    <= shreg_nxt;
         hist     <= hist_nxt;
         busy     <= busy_nxt;
         tx       <= tx_nxt;
         tx_valid <= tx_valid_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pre_cnt_nxt = pre_cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      bit_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = PRE;
               pre_cnt_nxt = 2'd0;
               bit_cnt_nxt = '0;
               shreg_nxt   = data_in;
               bit_nxt     = 1'b1;
            end
         end
         PRE: begin
            if (pre_cnt == 2'd2) begin
               state_nxt   = DATA;
               bit_nxt     = shreg[PAYLOAD_W-1];
               shreg_nxt   = {shreg[PAYLOAD_W-2:0], 1'b0};
               bit_cnt_nxt = bit_cnt + 1'b1;
            end else begin
               pre_cnt_nxt = pre_cnt + 2'd1;
               bit_nxt     = (pre_cnt == 2'd1);
            end
         end
         DATA: begin
            if (last_bit) begin
               state_nxt = IDLE;
            end else if (hist == 2'b10) begin
               state_nxt = STUFF;
               bit_nxt   = 1'b0;
            end else begin
               bit_nxt     = shreg[PAYLOAD_W-1];
               shreg_nxt   = {shreg[PAYLOAD_W-2:0], 1'b0};
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end
         STUFF: begin
            state_nxt   = DATA;
            bit_nxt     = shreg[PAYLOAD_W-1];
            shreg_nxt   = {shreg[PAYLOAD_W-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      hist_nxt = (state_nxt == IDLE) ? 2'b00 : {hist[0], bit_nxt};
   end

   always_comb begin
      busy_nxt     = (state_nxt != IDLE);
      tx_valid_nxt = busy_nxt;
      tx_nxt       = busy_nxt ? bit_nxt : IDLE_LEVEL;
      done_nxt     = (state == DATA) && last_bit;
   end

endmodule

// File: tb/tb_seq_101_frame_tx.sv
// Directed frames for seq_101_frame_tx.
// Expected tx streams are queued at stimulus time and popped by an independent output monitor.
module tb_seq_101_frame_tx;

   localparam int   PW       = 8;
   localparam logic IDLE_LVL = 1'b0;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [PW-1:0] data_in;
   logic          busy, tx, tx_valid, done;

   always #5 clk = ~clk;

   seq_101_frame_tx #(.PAYLOAD_W(PW), .IDLE_LEVEL(IDLE_LVL)) dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in),
      .busy(busy), .tx(tx), .tx_valid(tx_valid), .done(done)
   );

   int         vectors     = 0;
   int         miscompares = 0;
   logic [1:0] exp_q[$];     // {is_done, bit}
   bit         mon_en      = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [15:0] bits, input int n, input bit with_done);
      for (int i = n - 1; i >= 0; i--) exp_q.push_back({1'b0, bits[i]});
      if (with_done) exp_q.push_back(2'b10);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a frame now, optionally toggling start while busy, and returns in the done cycle.
   task automatic run_frame(input logic [7:0] d, input logic [15:0] bits, input int n,
                            input bit noise, input bit chain);
      int c;
      push_frame(bits, n, 1'b1);
      start   = 1'b1;
      data_in = d;
      step();
      start = 1'b0;
      check("accept_latency", {busy, tx_valid}, 2'b11);
      c = 1;
      while (done !== 1'b1 && c < 40) begin
         start   = noise && (c % 3 == 1) && (c < n - 1);
         data_in = noise ? 8'h00 : d;
         step();
         c++;
      end
      start = 1'b0;
      check("done_cycle", c, n + 1);
      if (!chain) begin
         step();
         step();
      end
   endtask

   // Monitor: pops one expected item per valid bit or done pulse.
   logic [1:0] item;
   int         det_s = 0;
   int         hits  = 0;
   bit         prev_valid = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (tx_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_bit: got tx=%0b expected none at %0t", tx, $time);
            end else begin
               item = exp_q.pop_front();
               check("tx_bit", {item[1], tx}, {1'b0, item[0]});
            end
            check("busy_with_valid", busy, 1'b1);
            case (det_s)
               0:       det_s = tx ? 1 : 0;
               1:       det_s = tx ? 1 : 2;
               default: begin
                  if (tx) hits++;
                  det_s = 0;
               end
            endcase
         end else begin
            check("idle_tx", tx, IDLE_LVL);
            check("idle_busy", busy, 1'b0);
            if (done) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
               end else begin
                  item = exp_q.pop_front();
                  check("done_marker", item, 2'b10);
               end
               check("done_after_bit", prev_valid, 1'b1);
               check("preamble_hits", hits, 1);
            end
            hits  = 0;
            det_s = 0;
         end
         if (reset) begin
            hits  = 0;
            det_s = 0;
         end
         prev_valid = tx_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      data_in = '0;
      step();
      step();
      start = 1'b1;
      data_in = 8'hFF;
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_tx", tx, IDLE_LVL);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_done", done, 1'b0);
      start  = 1'b0;
      mon_en = 1'b1;
      reset  = 1'b0;
      step();

      run_frame(8'hFF, 16'b0000010111111111, 11, 1'b0, 1'b0);
      run_frame(8'h55, 16'b0101001001001001, 15, 1'b0, 1'b0);
      run_frame(8'hA0, 16'b0001011001000000, 13, 1'b0, 1'b0);

      // Start pulses with new data while busy must not disturb the frame.
      run_frame(8'hFF, 16'b0000010111111111, 11, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("no_second_frame", busy, 1'b0);
         step();
      end

      // Abort a 55 frame in its 5th valid cycle.
      push_frame(16'b0000000000010100, 5, 1'b0);
      start   = 1'b1;
      data_in = 8'h55;
      step();
      start = 1'b0;
      check("abort_accept", tx_valid, 1'b1);
      repeat (4) step();
      reset = 1'b1;
      step();
      check("abort_busy", busy, 1'b0);
      check("abort_tx_valid", tx_valid, 1'b0);
      check("abort_tx", tx, IDLE_LVL);
      check("abort_done", done, 1'b0);
      reset = 1'b0;
      run_frame(8'hFF, 16'b0000010111111111, 11, 1'b0, 1'b0);

      // Back-to-back: start held through the done cycle of the first frame.
      run_frame(8'hA0, 16'b0001011001000000, 13, 1'b0, 1'b1);
      run_frame(8'h55, 16'b0101001001001001, 15, 1'b0, 1'b0);

      repeat (3) step();
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
